// File: rtl/knn_scheduler.sv
// knn_scheduler
//   Sequences one k-nearest-neighbour classification: a memory read, L
//   distance requests to a shared distance unit (one outstanding at a time),
//   an external sort, a K-cycle majority vote and a result write.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_start                      begin one classification (IDLE only)
//   o_read / i_read_done         memory read handshake
//   o_dist_req, o_dist_idx       distance request and sample index
//   i_dist_ack                   distance unit accepted the request
//   i_dist_valid                 result pulse with i_dist_value / i_dist_type
//   o_distance_array             collected distances, slot i at [i*W +: W]
//   o_type_array                 collected types, same packing
//   o_sort_start / i_sort_valid  sorter handshake
//   i_type_array_sorted          types in ascending-distance order
//   o_write / i_write_done       result write handshake
//   o_result_type                voted class
//   o_busy                       high whenever not IDLE
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for start
// READ   | read request held until read_done
// DIST   | collecting L distances, one request in flight
// SORT   | sort_start pulsed, waiting for sort_valid
// VOTE   | K cycles, one sorted neighbour counted per cycle
// WRITE  | write request held until write_done

module knn_scheduler #(
    parameter int L = 8,
    parameter int W = 16,
    parameter int K = 3,
    parameter int C = 4,
    localparam int IW = (L > 1) ? $clog2(L) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    output logic           o_read,
    input  logic           i_read_done,
    output logic           o_dist_req,
    output logic [IW-1:0]  o_dist_idx,
    input  logic           i_dist_ack,
    input  logic           i_dist_valid,
    input  logic [W-1:0]   i_dist_value,
    input  logic [W-1:0]   i_dist_type,
    output logic [L*W-1:0] o_distance_array,
    output logic [L*W-1:0] o_type_array,
    output logic           o_sort_start,
    input  logic           i_sort_valid,
    input  logic [L*W-1:0] i_type_array_sorted,
    output logic           o_write,
    input  logic           i_write_done,
    output logic [W-1:0]   o_result_type,
    output logic           o_busy
);

    localparam int CW  = $clog2(K + 1);
    localparam int VW  = (K > 1) ? $clog2(K) : 1;
    localparam int CIW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DIST,
        S_SORT,
        S_VOTE,
        S_WRITE
    } state_t;

    state_t         r_state;
    logic           r_read;
    logic           r_write;
    logic           r_dist_req;
    logic [IW-1:0]  r_dist_idx;
    logic           r_sort_start;
    logic [IW-1:0]  r_idx;
    logic           r_wait;        // request acked, result still pending
    logic [VW-1:0]  r_v;
    logic [CW-1:0]  r_cnt [C];
    logic [W-1:0]   r_result;
    logic [L*W-1:0] r_dist_arr;
    logic [L*W-1:0] r_type_arr;

    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_vote_type;
    logic [CW-1:0]  w_cnt_next [C];
    logic [CW-1:0]  w_best_cnt;
    logic [CIW-1:0] w_best_cls;

    // A result is only taken while a request is in flight: either already
    // acked, or being acked in this very cycle.
    assign w_accept = (r_state == S_DIST) && i_dist_valid &&
                      (r_wait || (r_dist_req && i_dist_ack));
    assign w_last   = (r_idx == IW'(L - 1));

    // Counts after this cycle's vote; the final vote cycle picks the winner
    // from these so VOTE lasts exactly K cycles.
    always_comb begin
        w_vote_type = i_type_array_sorted[r_v*W +: W];
        for (int c = 0; c < C; c++) begin
            w_cnt_next[c] = r_cnt[c];
            // Types >= C match no counter and are therefore not counted.
            if ((w_vote_type == W'(c)) && (r_cnt[c] != CW'(K)))
                w_cnt_next[c] = r_cnt[c] + CW'(1);
        end
        // Strict compare keeps the lowest class on ties and 0 when all zero.
        w_best_cls = '0;
        w_best_cnt = w_cnt_next[0];
        for (int c = 1; c < C; c++) begin
            if (w_cnt_next[c] > w_best_cnt) begin
                w_best_cnt = w_cnt_next[c];
                w_best_cls = CIW'(c);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_dist_req   <= 1'b0;
            r_dist_idx   <= '0;
            r_sort_start <= 1'b0;
            r_idx        <= '0;
            r_wait       <= 1'b0;
            r_v          <= '0;
            for (int c = 0; c < C; c++) r_cnt[c] <= '0;
            r_result     <= '0;
            r_dist_arr   <= '1;
            r_type_arr   <= '0;
        end else begin
            r_sort_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_read  <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (i_read_done) begin
                        r_read     <= 1'b0;
                        r_idx      <= '0;
                        r_dist_req <= 1'b1;
                        r_dist_idx <= '0;
                        r_wait     <= 1'b0;
                        r_state    <= S_DIST;
                    end
                end
                S_DIST: begin
                    if (r_dist_req && i_dist_ack) begin
                        r_dist_req <= 1'b0;
                        if (!i_dist_valid) r_wait <= 1'b1;
                    end
                    if (w_accept) begin
                        r_wait                   <= 1'b0;
                        r_dist_arr[r_idx*W +: W] <= i_dist_value;
                        r_type_arr[r_idx*W +: W] <= i_dist_type;
                        if (w_last) begin
                            r_sort_start <= 1'b1;
                            r_state      <= S_SORT;
                        end else begin
                            // Overrides the drop above when ack and valid coincide.
                            r_idx      <= r_idx + IW'(1);
                            r_dist_req <= 1'b1;
                            r_dist_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_SORT: begin
                    if (i_sort_valid) begin
                        for (int c = 0; c < C; c++) r_cnt[c] <= '0;
                        r_v     <= '0;
                        r_state <= S_VOTE;
                    end
                end
                S_VOTE: begin
                    for (int c = 0; c < C; c++) r_cnt[c] <= w_cnt_next[c];
                    if (r_v == VW'(K - 1)) begin
                        r_result <= W'(w_best_cls);
                        r_write  <= 1'b1;
                        r_state  <= S_WRITE;
                    end else begin
                        r_v <= r_v + VW'(1);
                    end
                end
                S_WRITE: begin
                    if (i_write_done) begin
                        r_write <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_read           = r_read;
    assign o_write          = r_write;
    assign o_dist_req       = r_dist_req;
    assign o_dist_idx       = r_dist_idx;
    assign o_sort_start     = r_sort_start;
    assign o_distance_array = r_dist_arr;
    assign o_type_array     = r_type_arr;
    assign o_result_type    = r_result;
    assign o_busy           = (r_state != S_IDLE);

endmodule

// File: doc/knn_scheduler.md
KNN_SCHEDULER -- requirements
Module: knn_scheduler

Interface
REQ-001 SHALL have parameter L, default 8: number of training samples.
REQ-002 SHALL have parameter W, default 16: distance/type word width.
REQ-003 SHALL have parameter K, default 3: neighbours voted, 1<=K<=L.
REQ-004 SHALL have parameter C, default 4: number of classes; IW=max(1,$clog2(L)).
REQ-005 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one classification.
- read  out  1  memory read request.
- read_done  in  1  memory read finished.
- dist_req  out  1  request to the shared distance unit.
- dist_idx  out  IW  training sample index for the request.
- dist_ack  in  1  distance unit accepted the request.
- dist_valid  in  1  result valid, one-cycle pulse.
- dist_value  in  W  distance result.
- dist_type  in  W  class of the sample.
- distance_array  out  L*W  collected distances, slot i at [i*W +: W].
- type_array  out  L*W  collected types, same packing.
- sort_start  out  1  one-cycle sorter start pulse.
- sort_valid  in  1  sorter finished.
- type_array_sorted  in  L*W  types in ascending-distance order.
- write  out  1  result write request.
- write_done  in  1  write finished.
- result_type  out  W  voted class.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 SHALL implement states IDLE, READ, DIST, SORT, VOTE, WRITE.
REQ-007 IDLE: on start=1, SHALL assert read and go to READ next cycle; start in any other state SHALL be ignored.
REQ-008 READ: read SHALL stay high until read_done=1; on that cycle SHALL deassert read, clear idx to 0 and go to DIST; without read_done SHALL stay in READ.
REQ-009 DIST: SHALL hold dist_req=1 with dist_idx=idx until dist_ack=1 is sampled, then SHALL drop dist_req.
REQ-010 DIST: SHALL allow at most one outstanding request; the next request SHALL NOT issue until dist_valid for the current index is received.
REQ-011 dist_valid may coincide with dist_ack; it SHALL then be accepted in the same cycle.
REQ-012 On an accepted dist_valid, SHALL write dist_value/dist_type into slot idx and increment idx.
REQ-013 dist_valid with no outstanding request SHALL be ignored, with no buffer write.
REQ-014 After slot L-1 is written, SHALL pulse sort_start for exactly one cycle on the next cycle and enter SORT.
REQ-015 SORT: SHALL wait for sort_valid=1, then clear the vote counters, set vote index v=0 and enter VOTE.
REQ-016 VOTE: SHALL spend exactly K cycles; in cycle v it SHALL increment the counter of class type_array_sorted slot v.
REQ-017 VOTE: types >= C SHALL not be counted.
REQ-018 Vote counters SHALL be $clog2(K+1) bits wide and SHALL never wrap.
REQ-019 After K cycles, SHALL register result_type as the class with the maximum count.
REQ-020 Ties SHALL resolve to the lowest class index; all counts zero SHALL give result_type=0.
REQ-021 After registering result_type, SHALL assert write and enter WRITE.
REQ-022 WRITE: write SHALL stay high until write_done=1; then SHALL deassert write and return to IDLE.
REQ-023 result_type SHALL hold its value until the next VOTE completes.
REQ-024 distance_array and type_array SHALL be stable from SORT entry until the next DIST write.
REQ-025 Handshake inputs arriving in a state that does not expect them SHALL be ignored.

Reset
REQ-026 Asserting rst SHALL, asynchronously and in any state, force state=IDLE.
REQ-027 Reset SHALL clear read, write, dist_req, sort_start and busy to 0, and dist_idx, idx and v to 0.
REQ-028 Reset SHALL set result_type to 0, vote counters to 0, every distance_array slot to all ones and every type_array slot to 0.
REQ-029 After rst deasserts, SHALL restart only on a new start.

Verification
REQ-030 Nominal: L=8, K=3, C=4; unit returns distance 10*i, type i%4; sorter echoes types -> sort_start 1 cycle after slot 7; result_type=0 (types 0,1,2 tie, lowest wins).
REQ-031 Majority: sorted types {2,2,1,...} -> result_type=2; write stays high until write_done.
REQ-032 Backpressure: dist_ack delayed 5 cycles, dist_valid 3 cycles later; dist_req and dist_idx held stable throughout -> no second request until valid.
REQ-033 Ack and valid in the same cycle for every index -> all 8 slots filled with correct values; no slot skipped.
REQ-034 Spurious dist_valid in IDLE, plus start during DIST -> buffers unchanged, run completes normally.
REQ-035 rst pulse mid-DIST at idx=4 -> immediately IDLE, dist_req=0, slots all ones/0; a fresh start completes correctly.
